// File: rtl/register_bank_be.sv
// ---------------------------------------------------------------------------
// register_bank_be
//
// Parametrised register bank that sits between the UART command parser and
// user logic. It holds DEPTH_RW read/write registers followed by DEPTH_RO
// read-only registers in one flat address map; anything above is unmapped.
//
//   Address map
//     0 .. DEPTH_RW-1                    RW registers (o_mem)
//     DEPTH_RW .. DEPTH_RW+DEPTH_RO-1    RO shadow registers
//     DEPTH_RW+DEPTH_RO ..               unmapped (read 0 + o_r_err)
//
// Features: byte-enabled writes, per-register write strobes, self-clearing
// "pulse" registers (PULSE_MASK), a coherent shadow snapshot of the RO
// inputs (i_ro_capture), a pipelined read port with 1 or 2 cycles of
// latency, and read/write address-error flags.
//
// Ports
//   clk           clock
//   i_reset       synchronous active-high reset
//   i_w_en        write request (one per cycle)
//   i_w_addr      write address
//   i_w_value     write data
//   i_w_be        byte enables, bit k covers bits [8k+7:8k]
//   i_r_en        read request (one per cycle)
//   i_r_addr      read address
//   o_r_value     read data, meaningful only while o_r_valid is high
//   o_r_valid     one-cycle read-data pulse
//   o_r_err       high with o_r_valid for an unmapped read address
//   o_w_err       one-cycle pulse after a write to an RO/unmapped address
//   o_w_strobe    bit i pulses the cycle after an accepted write to reg i
//   o_mem         live contents of the RW registers
//   i_mem_ro      live read-only sources
//   i_ro_capture  copy all i_mem_ro into the shadow bank
// ---------------------------------------------------------------------------
module register_bank_be #(
  parameter int                  WIDTH        = 32,
  parameter int                  DEPTH_RW     = 16,
  parameter int                  DEPTH_RO     = 16,
  parameter int                  ADDR_WIDTH   = 8,
  parameter int                  READ_LATENCY = 1,
  parameter logic [DEPTH_RW-1:0] PULSE_MASK   = '0
) (
  input  logic                               clk,
  input  logic                               i_reset,
  input  logic                               i_w_en,
  input  logic [ADDR_WIDTH-1:0]              i_w_addr,
  input  logic [WIDTH-1:0]                   i_w_value,
  input  logic [WIDTH/8-1:0]                 i_w_be,
  input  logic                               i_r_en,
  input  logic [ADDR_WIDTH-1:0]              i_r_addr,
  output logic [WIDTH-1:0]                   o_r_value,
  output logic                               o_r_valid,
  output logic                               o_r_err,
  output logic                               o_w_err,
  output logic [DEPTH_RW-1:0]                o_w_strobe,
  output logic [DEPTH_RW-1:0][WIDTH-1:0]     o_mem,
  input  logic [DEPTH_RO-1:0][WIDTH-1:0]     i_mem_ro,
  input  logic                               i_ro_capture
);

  localparam int BYTES = WIDTH / 8;

  // Region boundaries are one bit wider than the address so that a fully
  // populated map (DEPTH_RW+DEPTH_RO == 2**ADDR_WIDTH) still compares
  // correctly as unsigned values.
  localparam logic [ADDR_WIDTH:0] RO_BASE = (ADDR_WIDTH+1)'(DEPTH_RW);
  localparam logic [ADDR_WIDTH:0] RO_END  = (ADDR_WIDTH+1)'(DEPTH_RW + DEPTH_RO);

  logic [DEPTH_RW-1:0]            w_hit;
  logic                           w_bad;
  logic [DEPTH_RO-1:0][WIDTH-1:0] shadow;
  logic [WIDTH-1:0]               rd_data;
  logic                           rd_unmapped;
  logic [WIDTH-1:0]               s1_value;
  logic                           s1_valid;
  logic                           s1_err;

  // Write decode: one-hot hit vector over the RW registers, plus an error
  // flag for any write that lands in the RO or unmapped region.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < DEPTH_RW; i++) begin
      if (i_w_en && (i_w_addr == ADDR_WIDTH'(i))) begin
        w_hit[i] = 1'b1;
      end
    end
    w_bad = i_w_en && ({1'b0, i_w_addr} >= RO_BASE);
  end

  // RW storage. Only enabled bytes are updated; a hit with no byte enables
  // leaves the register untouched. Pulse registers fall back to zero on any
  // cycle they are not written, so a single write is visible for exactly one
  // cycle while back-to-back writes keep the newest value.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      o_mem <= '0;
    end else begin
      for (int i = 0; i < DEPTH_RW; i++) begin
        if (w_hit[i]) begin
          for (int k = 0; k < BYTES; k++) begin
            if (i_w_be[k]) begin
              o_mem[i][8*k +: 8] <= i_w_value[8*k +: 8];
            end
          end
        end else if (PULSE_MASK[i]) begin
          o_mem[i] <= '0;
        end
      end
    end
  end

  // Write side-band pulses: strobe for accepted RW writes (even with no byte
  // enables) and an error pulse for RO/unmapped writes.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      o_w_strobe <= '0;
      o_w_err    <= 1'b0;
    end else begin
      o_w_strobe <= w_hit;
      o_w_err    <= w_bad;
    end
  end

  // Shadow bank: the RO inputs are only ever observed through this snapshot,
  // so software sees a mutually consistent set of values.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      shadow <= '0;
    end else if (i_ro_capture) begin
      shadow <= i_mem_ro;
    end
  end

  // Read mux. It looks at the current register and shadow contents, so a
  // same-cycle write or capture is not yet visible (read-before-write).
  always_comb begin
    rd_data     = '0;
    rd_unmapped = ({1'b0, i_r_addr} >= RO_END);
    for (int i = 0; i < DEPTH_RW; i++) begin
      if (i_r_addr == ADDR_WIDTH'(i)) begin
        rd_data = o_mem[i];
      end
    end
    for (int j = 0; j < DEPTH_RO; j++) begin
      if (i_r_addr == ADDR_WIDTH'(DEPTH_RW + j)) begin
        rd_data = shadow[j];
      end
    end
  end

  // First read stage. Data and error only load on an accepted read so they
  // hold their last value between pulses; reset flushes the valid bit.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      s1_valid <= 1'b0;
      s1_value <= '0;
      s1_err   <= 1'b0;
    end else begin
      s1_valid <= i_r_en;
      if (i_r_en) begin
        s1_value <= rd_data;
        s1_err   <= rd_unmapped;
      end
    end
  end

  // READ_LATENCY == 2 adds one more output register; any other value is
  // treated as the single-stage configuration.
  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [WIDTH-1:0] s2_value;
      logic             s2_valid;
      logic             s2_err;

      always_ff @(posedge clk) begin
        if (i_reset) begin
          s2_valid <= 1'b0;
          s2_value <= '0;
          s2_err   <= 1'b0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            s2_value <= s1_value;
            s2_err   <= s1_err;
          end
        end
      end

      assign o_r_value = s2_value;
      assign o_r_valid = s2_valid;
      assign o_r_err   = s2_err;
    end else begin : g_lat1
      assign o_r_value = s1_value;
      assign o_r_valid = s1_valid;
      assign o_r_err   = s1_err;
    end
  endgenerate

endmodule

// File: tb/tb_register_bank_be.sv
// ---------------------------------------------------------------------------
// tb_register_bank_be
//
// Drives two register_bank_be instances (READ_LATENCY 1 and 2, register 5
// configured as a pulse register) from the same directed stimulus. Each read
// or write pushes its hand-computed response, with the cycle it must appear
// in, onto a queue; independent monitors pop and compare whenever a DUT
// presents read data or a write strobe/error pulse.
// ---------------------------------------------------------------------------
module tb_register_bank_be;

  localparam int              WIDTH      = 32;
  localparam int              DEPTH_RW   = 16;
  localparam int              DEPTH_RO   = 16;
  localparam int              ADDR_WIDTH = 8;
  localparam logic [15:0]     PULSE      = 16'h0020;

  typedef struct {
    logic [31:0] value;
    logic        err;
    int          cyc;
  } rd_exp_t;

  typedef struct {
    logic [15:0] strobe;
    logic        err;
    int          cyc;
  } wr_exp_t;

  logic                              clk = 1'b0;
  logic                              i_reset;
  logic                              i_w_en;
  logic [ADDR_WIDTH-1:0]             i_w_addr;
  logic [WIDTH-1:0]                  i_w_value;
  logic [WIDTH/8-1:0]                i_w_be;
  logic                              i_r_en;
  logic [ADDR_WIDTH-1:0]             i_r_addr;
  logic [DEPTH_RO-1:0][WIDTH-1:0]    i_mem_ro;
  logic                              i_ro_capture;

  logic [WIDTH-1:0]                  r_value1, r_value2;
  logic                              r_valid1, r_valid2;
  logic                              r_err1, r_err2;
  logic                              w_err1, w_err2;
  logic [DEPTH_RW-1:0]               w_strobe1, w_strobe2;
  logic [DEPTH_RW-1:0][WIDTH-1:0]    mem1, mem2;
  logic [DEPTH_RW-1:0][WIDTH-1:0]    exp_mem;

  rd_exp_t rd_q1[$];
  rd_exp_t rd_q2[$];
  wr_exp_t wr_q[$];
  rd_exp_t rd_e1, rd_e2;
  wr_exp_t wr_e;

  int cyc    = 0;
  int total  = 0;
  int bad    = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  register_bank_be #(
    .WIDTH(WIDTH), .DEPTH_RW(DEPTH_RW), .DEPTH_RO(DEPTH_RO),
    .ADDR_WIDTH(ADDR_WIDTH), .READ_LATENCY(1), .PULSE_MASK(PULSE)
  ) dut_lat1 (
    .clk(clk), .i_reset(i_reset),
    .i_w_en(i_w_en), .i_w_addr(i_w_addr), .i_w_value(i_w_value), .i_w_be(i_w_be),
    .i_r_en(i_r_en), .i_r_addr(i_r_addr),
    .o_r_value(r_value1), .o_r_valid(r_valid1), .o_r_err(r_err1),
    .o_w_err(w_err1), .o_w_strobe(w_strobe1), .o_mem(mem1),
    .i_mem_ro(i_mem_ro), .i_ro_capture(i_ro_capture)
  );

  register_bank_be #(
    .WIDTH(WIDTH), .DEPTH_RW(DEPTH_RW), .DEPTH_RO(DEPTH_RO),
    .ADDR_WIDTH(ADDR_WIDTH), .READ_LATENCY(2), .PULSE_MASK(PULSE)
  ) dut_lat2 (
    .clk(clk), .i_reset(i_reset),
    .i_w_en(i_w_en), .i_w_addr(i_w_addr), .i_w_value(i_w_value), .i_w_be(i_w_be),
    .i_r_en(i_r_en), .i_r_addr(i_r_addr),
    .o_r_value(r_value2), .o_r_valid(r_valid2), .o_r_err(r_err2),
    .o_w_err(w_err2), .o_w_strobe(w_strobe2), .o_mem(mem2),
    .i_mem_ro(i_mem_ro), .i_ro_capture(i_ro_capture)
  );

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one clock; single-cycle requests are dropped after the edge.
  task automatic apply_stimulus();
    @(posedge clk);
    #1;
    i_w_en       = 1'b0;
    i_r_en       = 1'b0;
    i_ro_capture = 1'b0;
  endtask

  task automatic set_write(input logic [7:0] addr, input logic [31:0] value,
                           input logic [3:0] be, input logic exp_err);
    i_w_en    = 1'b1;
    i_w_addr  = addr;
    i_w_value = value;
    i_w_be    = be;
    wr_q.push_back('{strobe: exp_err ? 16'h0 : (16'h1 << addr), err: exp_err, cyc: cyc + 1});
  endtask

  task automatic set_read(input logic [7:0] addr, input logic [31:0] exp_value, input logic exp_err);
    i_r_en   = 1'b1;
    i_r_addr = addr;
    rd_q1.push_back('{value: exp_value, err: exp_err, cyc: cyc + 1});
    rd_q2.push_back('{value: exp_value, err: exp_err, cyc: cyc + 2});
  endtask

  // Read monitor, latency-1 instance.
  always @(negedge clk) begin
    if (mon_en && r_valid1) begin
      if (rd_q1.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL rd1_unexpected: got o_r_valid=1, required 0 (cycle %0d)", cyc);
      end else begin
        rd_e1 = rd_q1.pop_front();
        check_output("rd1_cycle", 64'(cyc), 64'(rd_e1.cyc));
        check_output("rd1_value", 64'(r_value1), 64'(rd_e1.value));
        check_output("rd1_err", 64'(r_err1), 64'(rd_e1.err));
      end
    end
  end

  // Read monitor, latency-2 instance.
  always @(negedge clk) begin
    if (mon_en && r_valid2) begin
      if (rd_q2.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL rd2_unexpected: got o_r_valid=1, required 0 (cycle %0d)", cyc);
      end else begin
        rd_e2 = rd_q2.pop_front();
        check_output("rd2_cycle", 64'(cyc), 64'(rd_e2.cyc));
        check_output("rd2_value", 64'(r_value2), 64'(rd_e2.value));
        check_output("rd2_err", 64'(r_err2), 64'(rd_e2.err));
      end
    end
  end

  // Write side-band monitor: strobe/error pulses of both instances.
  always @(negedge clk) begin
    if (mon_en && ((w_strobe1 != '0) || w_err1 || (w_strobe2 != '0) || w_err2)) begin
      if (wr_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL wr_unexpected: got strobe=0x%0h err=%0b, required none (cycle %0d)",
                 w_strobe1, w_err1, cyc);
      end else begin
        wr_e = wr_q.pop_front();
        check_output("wr_cycle", 64'(cyc), 64'(wr_e.cyc));
        check_output("wr_strobe1", 64'(w_strobe1), 64'(wr_e.strobe));
        check_output("wr_err1", 64'(w_err1), 64'(wr_e.err));
        check_output("wr_strobe2", 64'(w_strobe2), 64'(wr_e.strobe));
        check_output("wr_err2", 64'(w_err2), 64'(wr_e.err));
      end
    end
  end

  initial begin
    i_reset      = 1'b1;
    i_w_en       = 1'b0;
    i_w_addr     = '0;
    i_w_value    = '0;
    i_w_be       = '0;
    i_r_en       = 1'b0;
    i_r_addr     = '0;
    i_mem_ro     = '0;
    i_ro_capture = 1'b0;

    apply_stimulus();
    apply_stimulus();
    i_reset = 1'b0;
    mon_en  = 1'b1;

    $display("[TB] reset state");
    check_output("rst_mem1_zero", 64'(mem1 == '0), 64'(1));
    check_output("rst_mem2_zero", 64'(mem2 == '0), 64'(1));
    check_output("rst_strobe", 64'(w_strobe1), 64'(0));
    check_output("rst_w_err", 64'(w_err1), 64'(0));
    check_output("rst_r_valid1", 64'(r_valid1), 64'(0));
    check_output("rst_r_valid2", 64'(r_valid2), 64'(0));
    check_output("rst_r_value", 64'(r_value1), 64'(0));
    check_output("rst_r_err", 64'(r_err1), 64'(0));

    $display("[TB] default reads");
    set_read(8'd0, 32'h0, 1'b0);
    apply_stimulus();
    set_read(8'd16, 32'h0, 1'b0);
    apply_stimulus();

    $display("[TB] byte-enabled writes");
    set_write(8'd3, 32'hDEADBEEF, 4'b1111, 1'b0);
    apply_stimulus();
    check_output("mem3_full", 64'(mem1[3]), 64'(32'hDEADBEEF));
    set_write(8'd3, 32'h00000011, 4'b0001, 1'b0);
    apply_stimulus();
    check_output("mem3_byte0", 64'(mem1[3]), 64'(32'hDEADBE11));
    set_read(8'd3, 32'hDEADBE11, 1'b0);
    apply_stimulus();

    $display("[TB] read-before-write");
    set_write(8'd3, 32'h00000000, 4'b1111, 1'b0);
    set_read(8'd3, 32'hDEADBE11, 1'b0);
    apply_stimulus();
    check_output("mem3_cleared", 64'(mem1[3]), 64'(0));
    set_read(8'd3, 32'h0, 1'b0);
    apply_stimulus();

    $display("[TB] zero byte enables and last RW register");
    set_write(8'd7, 32'hFFFFFFFF, 4'b0000, 1'b0);
    apply_stimulus();
    check_output("mem7_be0", 64'(mem1[7]), 64'(0));
    set_write(8'd15, 32'h13579BDF, 4'b1111, 1'b0);
    apply_stimulus();
    check_output("mem15", 64'(mem1[15]), 64'(32'h13579BDF));
    set_read(8'd15, 32'h13579BDF, 1'b0);
    apply_stimulus();

    $display("[TB] pulse register");
    set_write(8'd5, 32'h00000001, 4'b1111, 1'b0);
    apply_stimulus();
    check_output("pulse5_visible", 64'(mem1[5]), 64'(1));
    apply_stimulus();
    check_output("pulse5_cleared", 64'(mem1[5]), 64'(0));
    set_write(8'd5, 32'h00000002, 4'b1111, 1'b0);
    apply_stimulus();
    check_output("pulse5_b2b_first", 64'(mem1[5]), 64'(2));
    set_write(8'd5, 32'h00000003, 4'b1111, 1'b0);
    apply_stimulus();
    check_output("pulse5_b2b_second", 64'(mem1[5]), 64'(3));
    apply_stimulus();
    check_output("pulse5_b2b_cleared", 64'(mem1[5]), 64'(0));

    $display("[TB] RO capture");
    i_mem_ro[2]  = 32'hA5A5A5A5;
    i_mem_ro[15] = 32'hCAFEF00D;
    i_ro_capture = 1'b1;
    set_read(8'd18, 32'h0, 1'b0);
    apply_stimulus();
    i_mem_ro[2] = 32'h12345678;
    set_read(8'd18, 32'hA5A5A5A5, 1'b0);
    apply_stimulus();
    set_read(8'd31, 32'hCAFEF00D, 1'b0);
    apply_stimulus();

    $display("[TB] address errors");
    set_write(8'd16, 32'hFFFFFFFF, 4'b1111, 1'b1);
    apply_stimulus();
    set_write(8'd20, 32'hFFFFFFFF, 4'b1111, 1'b1);
    apply_stimulus();
    set_write(8'd200, 32'hFFFFFFFF, 4'b1111, 1'b1);
    apply_stimulus();
    exp_mem     = '0;
    exp_mem[15] = 32'h13579BDF;
    check_output("mem_after_bad_writes", 64'(mem1 == exp_mem), 64'(1));
    set_read(8'd200, 32'h0, 1'b1);
    apply_stimulus();
    set_read(8'd32, 32'h0, 1'b1);
    apply_stimulus();
    set_read(8'd20, 32'h0, 1'b0);
    apply_stimulus();

    $display("[TB] back-to-back reads");
    set_read(8'd15, 32'h13579BDF, 1'b0);
    apply_stimulus();
    set_read(8'd18, 32'hA5A5A5A5, 1'b0);
    apply_stimulus();
    set_read(8'd255, 32'h0, 1'b1);
    apply_stimulus();
    repeat (3) apply_stimulus();

    $display("[TB] reset mid-stream");
    // Only the single-stage instance delivers this read before reset lands.
    i_r_en   = 1'b1;
    i_r_addr = 8'd15;
    rd_q1.push_back('{value: 32'h13579BDF, err: 1'b0, cyc: cyc + 1});
    apply_stimulus();
    i_reset  = 1'b1;
    i_r_en   = 1'b1;
    i_r_addr = 8'd31;
    apply_stimulus();
    i_reset = 1'b0;
    repeat (5) apply_stimulus();

    check_output("post_rst_mem1_zero", 64'(mem1 == '0), 64'(1));
    check_output("post_rst_mem2_zero", 64'(mem2 == '0), 64'(1));
    check_output("post_rst_r_value", 64'(r_value1), 64'(0));
    check_output("post_rst_r_valid2", 64'(r_valid2), 64'(0));
    check_output("rd_q1_drained", 64'(rd_q1.size()), 64'(0));
    check_output("rd_q2_drained", 64'(rd_q2.size()), 64'(0));
    check_output("wr_q_drained", 64'(wr_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
